// File: rtl/noc_pkg.sv
// Shared BiNoC router definitions: sizes, port directions, channel numbering
// and the per-channel lock state.
package noc_pkg;

  localparam int NUM_IN = 5;
  localparam int NUM_CH = 10;
  localparam int SEL_W  = 3;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    EAST  = 3'd2,
    SOUTH = 3'd3,
    WEST  = 3'd4
  } port_e;

  typedef enum logic {
    CH_FREE   = 1'b0,
    CH_LOCKED = 1'b1
  } ch_state_e;

  // Each direction owns two bidirectional lanes: channel = direction*2 + lane.
  function automatic int ch_index(port_e dir, logic lane);
    return int'(dir) * 2 + int'(lane);
  endfunction

endpackage

// File: rtl/ch_alloc_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// ptr, wrapping around. The pointer register is owned by the caller.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int N = NUM_IN,
  parameter int W = SEL_W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic         valid
);

  // First pass takes the lowest requester at or above ptr; if none exists the
  // second pass takes the lowest requester overall, which is the wrap-around.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        valid    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!valid && req[i]) begin
        grant[i] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ch_alloc.sv
// Output-channel allocator: per-channel round-robin arbitration among the RC
// units, with the channel held for the whole packet until the owner releases.
//
// Per-channel state:
//   state     | meaning
//   CH_FREE   | channel idle, may be granted when its direction is outbound
//   CH_LOCKED | channel owned by owner[c] until that input pulses release
//
// The port named "release" in the router documentation is release_pulse here;
// "release" is a reserved word in SystemVerilog.
module ch_alloc #(
  parameter int NUM_IN = 5,
  parameter int NUM_CH = 10,
  parameter int SEL_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*NUM_CH-1:0] channel_req,
  input  logic [NUM_IN-1:0]        release_pulse,
  input  logic [NUM_CH-1:0]        ch_avail,
  output logic [NUM_IN-1:0]        gnt,
  output logic [NUM_IN*NUM_CH-1:0] gntOutCntr,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic [NUM_CH*SEL_W-1:0]  xbar_sel
);
  import noc_pkg::*;

  ch_state_e [NUM_CH-1:0]             st_q, st_d;
  logic [NUM_CH-1:0][SEL_W-1:0]       owner_q, owner_d;
  logic [NUM_CH-1:0][SEL_W-1:0]       ptr_q, ptr_d;
  logic [NUM_IN-1:0]                  gnt_q, gnt_d;
  logic [NUM_IN-1:0][NUM_CH-1:0]      gout_q, gout_d;

  logic [NUM_IN-1:0][NUM_CH-1:0]      req_lsb;
  logic [NUM_CH-1:0][NUM_IN-1:0]      req_col;
  logic [NUM_CH-1:0][NUM_IN-1:0]      win;
  logic [NUM_CH-1:0]                  win_v;

  // Eligibility: only the lowest set bit of each slice counts, the input must
  // be idle, and the channel must be free and currently outbound.
  always_comb begin
    req_lsb = '0;
    req_col = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      req_lsb[i] = channel_req[i*NUM_CH +: NUM_CH] &
                   (~channel_req[i*NUM_CH +: NUM_CH] + NUM_CH'(1));
    end
    for (int c = 0; c < NUM_CH; c++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        req_col[c][i] = req_lsb[i][c] & ~gnt_q[i] &
                        (st_q[c] == CH_FREE) & ch_avail[c];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_arb
    rr_arbiter #(.N(NUM_IN), .W(SEL_W)) u_arb (
      .req   (req_col[c]),
      .ptr   (ptr_q[c]),
      .grant (win[c]),
      .valid (win_v[c])
    );
  end

  // State register; async reset drops every lock at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= {NUM_CH{CH_FREE}};
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      gout_q  <= '0;
    end else begin
      st_q    <= st_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      gout_q  <= gout_d;
    end
  end

  // Next state: releases free channels; grants lock them. The two never touch
  // the same channel or input in one cycle, since a releasing input has gnt
  // set (so is not eligible) and its channel is still locked this cycle.
  always_comb begin
    st_d    = st_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    gout_d  = gout_q;
    for (int i = 0; i < NUM_IN; i++) begin
      if (release_pulse[i] && gnt_q[i]) begin
        gnt_d[i]  = 1'b0;
        gout_d[i] = '0;
        for (int c = 0; c < NUM_CH; c++) begin
          if (gout_q[i][c]) begin
            st_d[c]    = CH_FREE;
            owner_d[c] = '0;
          end
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (win_v[c]) begin
        st_d[c] = CH_LOCKED;
        for (int i = 0; i < NUM_IN; i++) begin
          if (win[c][i]) begin
            owner_d[c]   = SEL_W'(i);
            ptr_d[c]     = (i == NUM_IN - 1) ? '0 : SEL_W'(i + 1);
            gnt_d[i]     = 1'b1;
            gout_d[i][c] = 1'b1;
          end
        end
      end
    end
  end

  // Outputs come straight from registers; a free channel's owner is held at 0.
  always_comb begin
    gnt        = gnt_q;
    gntOutCntr = gout_q;
    xbar_sel   = owner_q;
    ch_busy    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_busy[c] = (st_q[c] == CH_LOCKED);
    end
  end

endmodule

// File: tb/tb_ch_alloc.sv
// Directed bench for ch_alloc: reset, single grant, round-robin contention,
// availability gating, release corner cases, illegal multi-bit request and
// asynchronous reset while locked.
module tb_ch_alloc;

  logic        clk = 1'b0;
  logic        rst;
  logic [49:0] channel_req;
  logic [4:0]  release_pulse;
  logic [9:0]  ch_avail;
  logic [4:0]  gnt;
  logic [49:0] gntOutCntr;
  logic [9:0]  ch_busy;
  logic [29:0] xbar_sel;

  int checks = 0;
  int errors = 0;

  ch_alloc dut (
    .clk           (clk),
    .rst           (rst),
    .channel_req   (channel_req),
    .release_pulse (release_pulse),
    .ch_avail      (ch_avail),
    .gnt           (gnt),
    .gntOutCntr    (gntOutCntr),
    .ch_busy       (ch_busy),
    .xbar_sel      (xbar_sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [9:0] v);
    channel_req[i*10 +: 10] = v;
  endtask

  function automatic logic [9:0] gout_s(input int i);
    return gntOutCntr[i*10 +: 10];
  endfunction

  function automatic logic [2:0] xs(input int c);
    return xbar_sel[c*3 +: 3];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    channel_req = '0;
    release_pulse = '0;
    ch_avail = '0;
    tick();
    tick();
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_gout", 64'(gntOutCntr), 64'h0);
    chk("rst_busy", 64'(ch_busy), 64'h0);
    chk("rst_xbar", 64'(xbar_sel), 64'h0);
    rst = 1'b0;
    ch_avail = 10'h3FF;
    tick();

    // Single grant
    set_req(0, 10'h008);
    tick();
    chk("single_gnt", 64'(gnt), 64'h01);
    chk("single_gout0", 64'(gout_s(0)), 64'h008);
    chk("single_busy", 64'(ch_busy), 64'h008);
    chk("single_xbar3", 64'(xs(3)), 64'h0);
    set_req(0, 10'h000);
    release_pulse = 5'b00001;
    tick();
    release_pulse = '0;
    chk("single_rel_gnt", 64'(gnt), 64'h00);
    chk("single_rel_busy", 64'(ch_busy), 64'h000);

    // Contention on channel 2, ptr[2]=0: input 1 wins
    set_req(1, 10'h004);
    set_req(4, 10'h004);
    tick();
    chk("cont1_gnt", 64'(gnt), 64'h02);
    chk("cont1_xbar2", 64'(xs(2)), 64'h1);
    chk("cont1_gout1", 64'(gout_s(1)), 64'h004);
    // Release input 1 at t, input 4 waits
    set_req(1, 10'h000);
    release_pulse = 5'b00010;
    tick();
    release_pulse = '0;
    chk("cont_rel_t1_gnt", 64'(gnt), 64'h00);
    chk("cont_rel_t1_busy", 64'(ch_busy), 64'h000);
    chk("cont_rel_t1_xbar2", 64'(xs(2)), 64'h0);
    tick();
    chk("cont_rel_t2_gnt", 64'(gnt), 64'h10);
    chk("cont_rel_t2_xbar2", 64'(xs(2)), 64'h4);
    chk("cont_rel_t2_gout4", 64'(gout_s(4)), 64'h004);
    set_req(4, 10'h000);
    release_pulse = 5'b10000;
    tick();
    release_pulse = '0;
    chk("cont_rel4_gnt", 64'(gnt), 64'h00);

    // ptr[2]=0 again: input 1 wins again
    set_req(1, 10'h004);
    set_req(4, 10'h004);
    tick();
    chk("cont2_gnt", 64'(gnt), 64'h02);
    chk("cont2_xbar2", 64'(xs(2)), 64'h1);
    set_req(1, 10'h000);
    set_req(4, 10'h000);
    release_pulse = 5'b00010;
    tick();
    release_pulse = '0;
    chk("cont2_rel_gnt", 64'(gnt), 64'h00);
    // ptr[2]=2 now: input 4 beats input 1
    set_req(1, 10'h004);
    set_req(4, 10'h004);
    tick();
    chk("cont3_gnt", 64'(gnt), 64'h10);
    chk("cont3_xbar2", 64'(xs(2)), 64'h4);
    set_req(1, 10'h000);
    set_req(4, 10'h000);
    release_pulse = 5'b10000;
    tick();
    release_pulse = '0;
    chk("cont3_rel_busy", 64'(ch_busy), 64'h000);

    // Availability gating on channel 5
    ch_avail = 10'h3DF;
    set_req(2, 10'h020);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("avail_low_gnt", 64'(gnt), 64'h00);
    end
    ch_avail = 10'h3FF;
    tick();
    chk("avail_up_gnt", 64'(gnt), 64'h04);
    chk("avail_up_busy", 64'(ch_busy), 64'h020);
    chk("avail_up_xbar5", 64'(xs(5)), 64'h2);
    ch_avail = 10'h3DF;
    tick();
    tick();
    chk("avail_drop_gnt", 64'(gnt), 64'h04);
    chk("avail_drop_busy", 64'(ch_busy), 64'h020);
    set_req(2, 10'h000);
    release_pulse = 5'b00100;
    tick();
    release_pulse = '0;
    ch_avail = 10'h3FF;
    chk("avail_rel_gnt", 64'(gnt), 64'h00);

    // Input 3 releases and re-requests channel 0 in the same cycle
    set_req(3, 10'h001);
    tick();
    chk("rr_grant_gnt", 64'(gnt), 64'h08);
    release_pulse = 5'b01000;
    tick();
    release_pulse = '0;
    chk("rr_t1_gnt", 64'(gnt), 64'h00);
    chk("rr_t1_busy", 64'(ch_busy), 64'h000);
    tick();
    chk("rr_t2_gnt", 64'(gnt), 64'h08);
    chk("rr_t2_gout3", 64'(gout_s(3)), 64'h001);
    // Spurious release from idle input 0
    release_pulse = 5'b00001;
    tick();
    release_pulse = '0;
    chk("spur_gnt", 64'(gnt), 64'h08);
    chk("spur_busy", 64'(ch_busy), 64'h001);
    chk("spur_xbar0", 64'(xs(0)), 64'h3);
    set_req(3, 10'h000);
    release_pulse = 5'b01000;
    tick();
    release_pulse = '0;
    chk("rr_rel_gnt", 64'(gnt), 64'h00);

    // Illegal multi-bit slice: only channel 2 taken
    set_req(1, 10'h00C);
    tick();
    chk("illegal_gnt", 64'(gnt), 64'h02);
    chk("illegal_gout1", 64'(gout_s(1)), 64'h004);
    chk("illegal_busy", 64'(ch_busy), 64'h004);
    chk("illegal_xbar2", 64'(xs(2)), 64'h1);
    chk("illegal_xbar3", 64'(xs(3)), 64'h0);

    // Second lock, then async reset mid-cycle
    set_req(4, 10'h080);
    tick();
    chk("prereset_gnt", 64'(gnt), 64'h12);
    chk("prereset_xbar7", 64'(xs(7)), 64'h4);
    #2;
    rst = 1'b1;
    #1;
    chk("async_gnt", 64'(gnt), 64'h00);
    chk("async_gout", 64'(gntOutCntr), 64'h0);
    chk("async_busy", 64'(ch_busy), 64'h000);
    chk("async_xbar", 64'(xbar_sel), 64'h0);
    channel_req = '0;
    tick();
    rst = 1'b0;
    set_req(0, 10'h010);
    #1;
    chk("postrst_idle_gnt", 64'(gnt), 64'h00);
    tick();
    chk("postrst_gnt", 64'(gnt), 64'h01);
    chk("postrst_busy", 64'(ch_busy), 64'h010);
    chk("postrst_xbar4", 64'(xs(4)), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
